// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo: write strobe and data in, line and status out.
// The host drives through master and the transmitter sits on slave.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 write;
    logic [DATA_BITS-1:0] write_value;
    logic                 uart_txd;
    logic                 busy;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 overflow;

    modport master (
        output write, write_value,
        input  uart_txd, busy, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  write, write_value,
        output uart_txd, busy, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small write FIFO and edge-qualified writes.
// The line and busy outputs are registered one cycle behind the FSM state.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk_50M,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

    state_t               state, state_nxt;
    logic [BW-1:0]        baud_cnt, baud_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bit, par_nxt;
    logic                 baud_end, line;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_nxt;
    logic                 write_d, wr_edge, full_now, push, pop;
    logic                 txd_q, busy_q, full_q, empty_q, ovf_q;

    assign wr_edge  = bus.write & ~write_d;
    assign full_now = (count == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign push     = wr_edge & (~full_now | pop);
    assign baud_end = (baud_cnt == BW'(DIV - 1));

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        pop       = 1'b0;
        line      = 1'b1;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    shreg_nxt = mem[rd_ptr];
                    par_nxt   = (^mem[rd_ptr]) ^ (PARITY == 1);
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                line = 1'b0;
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            ST_DATA: begin
                line = shreg[0];
                if (baud_end) begin
                    baud_nxt  = '0;
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            ST_PAR: begin
                line = par_bit;
                if (baud_end) begin
                    baud_nxt  = '0;
                    state_nxt = ST_STOP;
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        bit_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_nxt;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_50M) begin
        if (push) mem[wr_ptr] <= bus.write_value;
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            write_d <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            write_d <= bus.write;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_nxt;
            txd_q   <= line;
            busy_q  <= (state != ST_IDLE);
            full_q  <= (count_nxt == CW'(FIFO_DEPTH));
            empty_q <= (count_nxt == '0);
            ovf_q   <= wr_edge & full_now & ~pop;
        end
    end

    assign bus.uart_txd   = txd_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 8E1, 7O2) at DIV=10 against a
// queue-and-waveform model, plus literal frame decodes at mid-bit.
module tb_uart_tx_fifo;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       w  [3];
    logic [8:0] wv [3];
    logic [2:0] txd, busy, full, empty, ovf;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) b0 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) b1 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) b2 ();

    assign b0.write = w[0];  assign b0.write_value = wv[0][7:0];
    assign b1.write = w[1];  assign b1.write_value = wv[1][7:0];
    assign b2.write = w[2];  assign b2.write_value = wv[2][6:0];
    assign txd   = {b2.uart_txd,   b1.uart_txd,   b0.uart_txd};
    assign busy  = {b2.busy,       b1.busy,       b0.busy};
    assign full  = {b2.fifo_full,  b1.fifo_full,  b0.fifo_full};
    assign empty = {b2.fifo_empty, b1.fifo_empty, b0.fifo_empty};
    assign ovf   = {b2.overflow,   b1.overflow,   b0.overflow};

    uart_tx_fifo #(.BAUD(5_000_000)) u0 (.clk_50M(clk), .reset(reset), .bus(b0));
    uart_tx_fifo #(.BAUD(5_000_000), .PARITY(2)) u1 (.clk_50M(clk), .reset(reset), .bus(b1));
    uart_tx_fifo #(.BAUD(5_000_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
        u2 (.clk_50M(clk), .reset(reset), .bus(b2));

    function automatic int dbw(input int i); return (i == 2) ? 7 : 8; endfunction
    function automatic int prm(input int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
    function automatic int sbt(input int i); return (i == 2) ? 2 : 1; endfunction

    // Model: FIFO contents as a ring of characters, transmitter as an expanded frame waveform.
    logic [8:0] mq [3][DEPTH];
    int  mh [3], mn [3], k [3], T [3];
    bit  frm [3][140];
    bit  prev [3];
    bit  e_txd [3], e_busy [3], e_full [3], e_empty [3], e_ovf [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic build(input int i, input logic [8:0] d);
        bit b [13];
        int nb, ones;
        b[0] = 1'b0; nb = 1; ones = 0;
        for (int j = 0; j < dbw(i); j++) begin
            b[nb] = d[j]; ones += int'(d[j]); nb++;
        end
        if (prm(i) != 0) begin
            b[nb] = (prm(i) == 1) ? (ones % 2 == 0) : (ones % 2 == 1); nb++;
        end
        for (int j = 0; j < sbt(i); j++) begin b[nb] = 1'b1; nb++; end
        for (int j = 0; j < nb * DIV; j++) frm[i][j] = b[j / DIV];
        T[i] = nb * DIV;
    endtask

    task automatic mreset(input int i);
        mh[i] = 0; mn[i] = 0; k[i] = -1; prev[i] = 1'b0;
        e_txd[i] = 1'b1; e_busy[i] = 1'b0; e_full[i] = 1'b0; e_empty[i] = 1'b1; e_ovf[i] = 1'b0;
    endtask

    task automatic mstep(input int i);
        bit ed, fl, pp;
        ed = w[i] && !prev[i];
        prev[i] = w[i];
        fl = (mn[i] == DEPTH);
        pp = 1'b0;
        if (k[i] >= 0) begin
            e_txd[i] = frm[i][k[i]]; e_busy[i] = 1'b1; k[i]++;
            if (k[i] == T[i]) k[i] = -1;
        end else begin
            e_txd[i] = 1'b1; e_busy[i] = 1'b0;
            if (mn[i] > 0) begin
                build(i, mq[i][mh[i]]);
                mh[i] = (mh[i] + 1) % DEPTH; mn[i]--; k[i] = 0; pp = 1'b1;
            end
        end
        if (ed && (!fl || pp)) begin
            mq[i][(mh[i] + mn[i]) % DEPTH] = wv[i]; mn[i]++;
        end
        e_ovf[i]   = ed && fl && !pp;
        e_full[i]  = (mn[i] == DEPTH);
        e_empty[i] = (mn[i] == 0);
    endtask

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) mreset(i); else mstep(i);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.txd", i),   32'(txd[i]),   32'(e_txd[i]));
            chk($sformatf("u%0d.busy", i),  32'(busy[i]),  32'(e_busy[i]));
            chk($sformatf("u%0d.full", i),  32'(full[i]),  32'(e_full[i]));
            chk($sformatf("u%0d.empty", i), 32'(empty[i]), 32'(e_empty[i]));
            chk($sformatf("u%0d.ovf", i),   32'(ovf[i]),   32'(e_ovf[i]));
        end
    end

    // Waits for a start bit, then samples each bit mid-cell while busy is high.
    task automatic rx(input int i, output logic [8:0] d, output logic pb, output int lat,
                      output int len, output logic [12:0] bits);
        int n;
        bits = '0; d = '0; lat = 0;
        @(negedge clk);
        while (txd[i] && lat < 400) begin lat++; @(negedge clk); end
        n = 0;
        while (busy[i] && n < 300) begin
            if (n % DIV == DIV / 2 && n / DIV < 13) bits[n / DIV] = txd[i];
            n++;
            @(negedge clk);
        end
        len = n;
        for (int j = 0; j < dbw(i); j++) d[j] = bits[1 + j];
        pb = bits[1 + dbw(i)];
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  d [3];
        logic        pb [3];
        int          lat [3], len [3];
        logic [12:0] bits [3];
        int          ov, fs, n;
        for (int i = 0; i < 3; i++) begin w[i] = 1'b0; wv[i] = '0; end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.txd", 32'(txd[0]), 1); chk("rst.busy", 32'(busy[0]), 0);
        chk("rst.empty", 32'(empty[0]), 1); chk("rst.full", 32'(full[0]), 0);
        chk("rst.ovf", 32'(ovf[0]), 0);
        @(posedge clk); #2 reset = 1'b0;
        repeat (3) @(posedge clk); #2;

        // Single frames on all three configurations, 25-cycle write level
        fork
            begin
                for (int i = 0; i < 3; i++) w[i] = 1'b1;
                wv[0] = 9'h21; wv[1] = 9'h43; wv[2] = 9'h65;
                repeat (25) @(posedge clk); #2;
                for (int i = 0; i < 3; i++) w[i] = 1'b0;
            end
            rx(0, d[0], pb[0], lat[0], len[0], bits[0]);
            rx(1, d[1], pb[1], lat[1], len[1], bits[1]);
            rx(2, d[2], pb[2], lat[2], len[2], bits[2]);
        join
        chk("8N1.lat", 32'(lat[0]), 3);
        chk("8N1.bits", 32'(bits[0][9:0]), 32'b1001000010);
        chk("8N1.len", 32'(len[0]), 100);
        chk("8E1.lat", 32'(lat[1]), 3);
        chk("8E1.data", 32'(d[1]), 32'h43);
        chk("8E1.par", 32'(pb[1]), 1);
        chk("8E1.stop", 32'(bits[1][10]), 1);
        chk("8E1.len", 32'(len[1]), 110);
        chk("7O2.lat", 32'(lat[2]), 3);
        chk("7O2.data", 32'(d[2]), 32'h65);
        chk("7O2.par", 32'(pb[2]), 1);
        chk("7O2.stop", 32'(bits[2][10:9]), 32'b11);
        chk("7O2.len", 32'(len[2]), 110);
        chk("model.T0", 32'(T[0]), 100);
        chk("model.T2", 32'(T[2]), 110);
        chk("model.par1", 32'(frm[1][95]), 1);
        chk("model.par2", 32'(frm[2][85]), 1);
        repeat (30) @(negedge clk);
        chk("single.empty", 32'(empty[0]), 1);
        chk("single.busy", 32'(busy[0]), 0);
        @(posedge clk); #2;

        // Burst of six edges three cycles apart: five frames, one drop
        fork
            begin
                for (int v = 1; v <= 6; v++) begin
                    w[0] = 1'b1; wv[0] = 9'(v);
                    @(posedge clk); #2 w[0] = 1'b0;
                    repeat (2) @(posedge clk); #2;
                end
            end
            begin
                ov = 0; fs = 0;
                repeat (60) begin @(negedge clk); ov += int'(ovf[0]); fs |= int'(full[0]); end
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    rx(0, d[0], pb[0], lat[0], len[0], bits[0]);
                    chk($sformatf("burst.data%0d", f), 32'(d[0]), 32'(f + 1));
                    chk($sformatf("burst.lat%0d", f), 32'(lat[0]), (f == 0) ? 3 : 0);
                end
            end
        join
        chk("burst.ovf_pulses", 32'(ov), 1);
        chk("burst.full_seen", 32'(fs), 1);
        repeat (20) @(negedge clk);
        chk("burst.no6th", 32'({busy[0], empty[0]}), 32'b01);
        @(posedge clk); #2;

        // Push arriving in the pop cycle with the FIFO full
        w[0] = 1'b1; wv[0] = 9'hA0;
        @(posedge clk); #2 w[0] = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            @(posedge clk); #2 w[0] = 1'b1; wv[0] = 9'(8'hA0 + v);
            @(posedge clk); #2 w[0] = 1'b0;
        end
        @(negedge clk);
        chk("pp.full_before", 32'(full[0]), 1);
        repeat (93) @(posedge clk);
        #2 w[0] = 1'b1; wv[0] = 9'hA5;
        @(posedge clk); #2 w[0] = 1'b0;
        @(negedge clk);
        chk("pp.ovf", 32'(ovf[0]), 0);
        chk("pp.full", 32'(full[0]), 1);
        chk("pp.busy_gap", 32'(busy[0]), 0);
        n = 0;
        while (!(empty[0] && !busy[0]) && n < 800) begin n++; @(negedge clk); end
        chk("pp.drained", 32'(n < 800), 1);
        @(posedge clk); #2;

        // Reset during data bit 3 of 0x55 with two entries queued
        w[0] = 1'b1; wv[0] = 9'h55;
        @(posedge clk); #2 w[0] = 1'b0;
        @(posedge clk); #2 w[0] = 1'b1; wv[0] = 9'h11;
        @(posedge clk); #2 w[0] = 1'b0;
        @(posedge clk); #2 w[0] = 1'b1; wv[0] = 9'h22;
        @(posedge clk); #2 w[0] = 1'b0;
        repeat (41) @(posedge clk); #2;
        chk("mid.bit3", 32'(txd[0]), 0);
        chk("mid.queued", 32'({busy[0], empty[0]}), 32'b10);
        reset = 1'b1;
        #1;
        chk("mid.rst_txd", 32'(txd[0]), 1);
        chk("mid.rst_empty", 32'(empty[0]), 1);
        chk("mid.rst_busy", 32'(busy[0]), 0);
        repeat (3) @(posedge clk); #2 reset = 1'b0;
        fs = 0;
        repeat (300) begin @(negedge clk); fs |= int'(busy[0]) | int'(!txd[0]); end
        chk("mid.no_resume", 32'(fs), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
